// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall detection, branch flush gating and EX-stage
// operand forwarding, driven by shadow copies of the EX/MEM/WB destination info.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [4:0]       ex_rs1_q, ex_rs1_d;
    logic [4:0]       ex_rs2_q, ex_rs2_d;
    logic             ex_reg_write_q, ex_reg_write_d;
    logic             ex_mem_read_q, ex_mem_read_d;
    logic [4:0]       mem_rd_q, mem_rd_d;
    logic             mem_reg_write_q, mem_reg_write_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall;

    // arst_n in the term drops a stall the moment reset asserts, independent of flop timing
    always_comb begin
        stall = arst_n & id_valid & ex_mem_read_q & (ex_rd_q != 5'd0) &
                ((ex_rd_q == id_rs1) | (id_uses_rs2 & (ex_rd_q == id_rs2)));
    end

    always_comb begin
        ex_rd_d         = 5'd0;
        ex_rs1_d        = 5'd0;
        ex_rs2_d        = 5'd0;
        ex_reg_write_d  = 1'b0;
        ex_mem_read_d   = 1'b0;
        if (!stall && id_valid) begin
            ex_rd_d        = id_rd;
            ex_rs1_d       = id_rs1;
            ex_rs2_d       = id_rs2;
            ex_reg_write_d = id_reg_write;
            ex_mem_read_d  = id_mem_read;
        end
        mem_rd_d        = ex_rd_q;
        mem_reg_write_d = ex_reg_write_q;
        wb_rd_d         = mem_rd_q;
        wb_reg_write_d  = mem_reg_write_q;
        stall_cnt_d     = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_rd_q         <= 5'd0;
            ex_rs1_q        <= 5'd0;
            ex_rs2_q        <= 5'd0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_rd_q        <= 5'd0;
            mem_reg_write_q <= 1'b0;
            wb_rd_q         <= 5'd0;
            wb_reg_write_q  <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            ex_rd_q         <= ex_rd_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_rd_q        <= mem_rd_d;
            mem_reg_write_q <= mem_reg_write_d;
            wb_rd_q         <= wb_rd_d;
            wb_reg_write_q  <= wb_reg_write_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    // MEM result is younger than WB, so it wins when both match
    always_comb begin
        fwd_a = 2'b00;
        if (mem_reg_write_q && (mem_rd_q != 5'd0) && (mem_rd_q == ex_rs1_q)) begin
            fwd_a = 2'b10;
        end else if (wb_reg_write_q && (wb_rd_q != 5'd0) && (wb_rd_q == ex_rs1_q)) begin
            fwd_a = 2'b01;
        end
        fwd_b = 2'b00;
        if (mem_reg_write_q && (mem_rd_q != 5'd0) && (mem_rd_q == ex_rs2_q)) begin
            fwd_b = 2'b10;
        end else if (wb_reg_write_q && (wb_rd_q != 5'd0) && (wb_rd_q == ex_rs2_q)) begin
            fwd_b = 2'b01;
        end
    end

    assign pc_write     = ~stall;
    assign if_id_write  = ~stall;
    assign id_ex_bubble = stall;
    assign if_id_flush  = arst_n & flush_req & ~stall;
    assign stall_cnt    = stall_cnt_q;

endmodule
